// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and segment encoding for the display scan controller.
// Segment byte layout: bit 7 = a ... bit 1 = g, bit 0 = dp; all patterns active high.
package display_pkg;

   typedef enum logic [1:0] {
      S_ON    = 2'd0,
      S_BLANK = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   localparam logic [7:0] SEG_DP   = 8'h01;
   localparam logic [7:0] SEG_AG   = 8'hFE;
   localparam logic [7:0] SEG_NONE = 8'h00;

   function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
      logic [7:0] s;
      case (nibble)
         4'h0: s = 8'hFC;
         4'h1: s = 8'h60;
         4'h2: s = 8'hDA;
         4'h3: s = 8'hF2;
         4'h4: s = 8'h66;
         4'h5: s = 8'hB6;
         4'h6: s = 8'hBE;
         4'h7: s = 8'hE0;
         4'h8: s = 8'hFE;
         4'h9: s = 8'hF6;
         4'hA: s = 8'hEE;
         4'hB: s = 8'h3E;
         4'hC: s = 8'h9C;
         4'hD: s = 8'h7A;
         4'hE: s = 8'h9E;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble plus decimal point to active-high segment pattern.
module hex_to_seg
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);

   assign seg = (hex_seg(nibble) & SEG_AG) | (dp ? SEG_DP : SEG_NONE);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame snapshot and inter-digit blanking.
// Optional brightness PWM enabled by defining DISPLAY_SCAN_CTRL_PWM_EN.
//
//  state   | meaning
//  S_ON    | selected digit driven, waiting for slot tick
//  S_BLANK | all digits off, segments reloaded on exit
//  S_LOAD  | new segments on pins, digits still off
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int n_dig          = 8,
   parameter int w_cnt          = 16,
   parameter bit seg_active_low = 1'b1,
   parameter bit dig_active_low = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [n_dig*4-1:0] number,
   input  logic [n_dig-1:0]   dots,
   input  logic               lz_en,
`ifdef DISPLAY_SCAN_CTRL_PWM_EN
   input  logic [3:0]         brightness,
`endif
   output logic [7:0]         abcdefgh,
   output logic [n_dig-1:0]   digit,
   output logic               frame_start
);

   localparam int IW = (n_dig > 1) ? $clog2(n_dig) : 1;
   localparam logic [IW-1:0]    IDX_LAST = IW'(n_dig - 1);
   localparam logic [7:0]       SEG_POL  = seg_active_low ? 8'hFF : 8'h00;
   localparam logic [n_dig-1:0] DIG_POL  = dig_active_low ? '1 : '0;

   state_t             state;
   logic               run;
   logic [w_cnt-1:0]   cnt;
   logic [IW-1:0]      idx;
   logic [n_dig*4-1:0] snap_num;
   logic [n_dig-1:0]   snap_dots;
   logic               snap_lz;
   logic               tick;
   logic               upper_zero;
   logic               blank;
   logic [3:0]         nibble;
   logic [7:0]         seg_raw;
   logic [7:0]         seg_nxt;
   logic [n_dig-1:0]   dig_oh;
   logic               gate;

   assign tick   = &cnt;
   assign nibble = snap_num[{idx, 2'b00} +: 4];

   always_comb begin
      upper_zero = 1'b1;
      for (int j = 0; j < n_dig; j++) begin
         if (IW'(j) >= idx && snap_num[j*4 +: 4] != 4'h0) upper_zero = 1'b0;
      end
   end

   // Digit 0 always shows something, even when the whole value is zero.
   assign blank = snap_lz && (idx != '0) && upper_zero;

   hex_to_seg u_hex_to_seg (
      .nibble (nibble),
      .dp     (snap_dots[idx]),
      .seg    (seg_raw)
   );

   assign seg_nxt = blank ? (seg_raw & SEG_DP) : seg_raw;

   always_comb begin
      dig_oh      = '0;
      dig_oh[idx] = 1'b1;
   end

`ifdef DISPLAY_SCAN_CTRL_PWM_EN
   logic [3:0]       snap_bri;
   logic [w_cnt-1:0] cnt_nxt;
   // Gate on the count the pins will see next cycle so the duty lines up with cnt.
   assign cnt_nxt = cnt + w_cnt'(1);
   assign gate    = (snap_bri == 4'hF) || (cnt_nxt[w_cnt-1 -: 4] < snap_bri);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         snap_bri <= 4'h0;
      else if (tick && idx == IDX_LAST)  snap_bri <= brightness;
   end
`else
   assign gate = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_BLANK;
         run         <= 1'b0;
         cnt         <= '0;
         idx         <= IDX_LAST;
         snap_num    <= '0;
         snap_dots   <= '0;
         snap_lz     <= 1'b0;
         abcdefgh    <= SEG_NONE ^ SEG_POL;
         digit       <= '0 ^ DIG_POL;
         frame_start <= 1'b0;
      end else begin
         cnt         <= cnt + w_cnt'(1);
         frame_start <= 1'b0;
         if (tick) begin
            run   <= 1'b1;
            state <= S_BLANK;
            digit <= '0 ^ DIG_POL;
            if (idx == IDX_LAST) begin
               idx         <= '0;
               snap_num    <= number;
               snap_dots   <= dots;
               snap_lz     <= lz_en;
               frame_start <= 1'b1;
            end else begin
               idx <= idx + IW'(1);
            end
         end else begin
            case (state)
               S_BLANK: begin
                  // Stay dark after reset until the first tick has taken a snapshot.
                  if (run) begin
                     abcdefgh <= seg_nxt ^ SEG_POL;
                     state    <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  digit <= (dig_oh & {n_dig{gate}}) ^ DIG_POL;
                  state <= S_ON;
               end
               default: begin
                  digit <= (dig_oh & {n_dig{gate}}) ^ DIG_POL;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: n_dig = 8, w_cnt = 4, active-low pins.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] number;
   logic [7:0]  dots;
   logic        lz_en;
   logic [7:0]  abcdefgh;
   logic [7:0]  digit;
   logic        frame_start;
`ifdef DISPLAY_SCAN_CTRL_PWM_EN
   logic [3:0]  brightness;
`endif

   int checks = 0;
   int errors = 0;

   display_scan_ctrl #(
      .n_dig(8), .w_cnt(4), .seg_active_low(1'b1), .dig_active_low(1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .number      (number),
      .dots        (dots),
      .lz_en       (lz_en),
`ifdef DISPLAY_SCAN_CTRL_PWM_EN
      .brightness  (brightness),
`endif
      .abcdefgh    (abcdefgh),
      .digit       (digit),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Active-low segment codes for hex 0..F, dp off.
   function automatic logic [7:0] seg_lo(input logic [3:0] n);
      logic [7:0] t [16];
      t = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
      return t[n];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_start !== 1'b1 && n < 300);
      chk("frame_wait", {31'd0, frame_start}, 32'd1);
   endtask

   // Entered at the first off cycle of slot k; leaves at the first cycle of slot k+1.
   task automatic run_slot(input int k, input logic [7:0] seg);
      logic [7:0] on_pat;
      on_pat = ~(8'h01 << k);
      chk($sformatf("gap0_d%0d", k), {24'd0, digit}, 32'hFF);
      @(negedge clk);
      chk($sformatf("gap1_d%0d", k), {24'd0, digit}, 32'hFF);
      chk($sformatf("seg_early_d%0d", k), {24'd0, abcdefgh}, {24'd0, seg});
      @(negedge clk);
      chk($sformatf("on_first_d%0d", k), {24'd0, digit}, {24'd0, on_pat});
      chk($sformatf("seg_d%0d", k), {24'd0, abcdefgh}, {24'd0, seg});
      repeat (13) @(negedge clk);
      chk($sformatf("on_last_d%0d", k), {24'd0, digit}, {24'd0, on_pat});
      @(negedge clk);
   endtask

   task automatic run_frame(input logic [63:0] exp);
      for (int k = 0; k < 8; k++) run_slot(k, exp[8*k +: 8]);
      chk("frame_period", {31'd0, frame_start}, 32'd1);
   endtask

`ifdef DISPLAY_SCAN_CTRL_PWM_EN
   task automatic pwm_count(input logic [3:0] b, input int exp_on);
      int on = 0;
      brightness = b;
      wait_frame();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         if (digit == 8'hFE) on++;
         @(negedge clk);
      end
      chk($sformatf("pwm_b%0d", b), on, exp_on);
   endtask
`endif

   initial begin
      reset  = 1'b1;
      number = 32'h12345678;
      dots   = 8'h00;
      lz_en  = 1'b0;
`ifdef DISPLAY_SCAN_CTRL_PWM_EN
      brightness = 4'hF;
`endif
      repeat (5) @(negedge clk);
      chk("rst_seg", {24'd0, abcdefgh}, 32'hFF);
      chk("rst_dig", {24'd0, digit}, 32'hFF);
      chk("rst_fs", {31'd0, frame_start}, 32'd0);
      reset = 1'b0;

      // Plain digits: digit k shows nibble k.
      wait_frame();
      begin
         logic [63:0] e;
         for (int k = 0; k < 8; k++) e[8*k +: 8] = seg_lo(number[4*k +: 4]);
         run_frame(e);
      end

      // Leading-zero suppression.
      lz_en  = 1'b1;
      number = 32'h00000120;
      wait_frame();
      run_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h9F, 8'h25, 8'h03});

      number = 32'h0;
      wait_frame();
      run_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03});

      dots = 8'h80;
      wait_frame();
      run_frame({8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03});

      // Mid-frame change must not tear.
      lz_en  = 1'b0;
      dots   = 8'h00;
      number = 32'h12345678;
      wait_frame();
      for (int k = 0; k < 4; k++) run_slot(k, seg_lo(4'(8 - k)));
      number = 32'hABCDEF01;
      run_slot(4, 8'h99);
      run_slot(5, 8'h0D);
      run_slot(6, 8'h25);
      run_slot(7, 8'h9F);
      chk("fs_after_change", {31'd0, frame_start}, 32'd1);
      run_frame({8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71, 8'h03, 8'h9F});

      // Asynchronous reset mid-slot, then restart at digit 0.
      repeat (5) @(negedge clk);
      chk("pre_rst_dig", {24'd0, digit}, 32'hFE);
      reset = 1'b1;
      #1;
      chk("mid_rst_seg", {24'd0, abcdefgh}, 32'hFF);
      chk("mid_rst_dig", {24'd0, digit}, 32'hFF);
      chk("mid_rst_fs", {31'd0, frame_start}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_frame();
      run_slot(0, 8'h9F);
      run_slot(1, 8'h03);

`ifdef DISPLAY_SCAN_CTRL_PWM_EN
      pwm_count(4'd0, 0);
      pwm_count(4'd15, 14);
      pwm_count(4'd8, 6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
